// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for one shared 32-bit shift unit.
// A single registered result slot holds each result until its owner consumes it.
module shift_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [15:0]      op_count
);

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_ROTL = 2'b10;
    localparam logic [1:0] OP_SRA  = 2'b11;

    logic             full_q, full_d;
    logic             owner_q, owner_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [15:0]      cnt_q, cnt_d;

    logic             drain;
    logic             free;
    logic             grant0;
    logic             grant1;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [4:0]       sel_s;
    logic [WIDTH-1:0] shift_res;

    function automatic logic [WIDTH-1:0] do_shift(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [4:0] s);
        logic [WIDTH-1:0] r;
        r = a;
        case (op)
            OP_SLL:  r = a << s;
            OP_SRL:  r = a >> s;
            // s=0 would shift right by the full width, so return a directly
            OP_ROTL: r = (s == 5'd0) ? a : ((a << s) | (a >> (6'd32 - {1'b0, s})));
            OP_SRA:  r = $unsigned($signed(a) >>> s);
            default: r = a;
        endcase
        return r;
    endfunction

    always_comb begin
        drain     = full_q && (owner_q ? rsp1_ready : rsp0_ready);
        free      = !full_q || drain;
        // reqN_ready is forced low while reset is held even though the slot is empty
        grant0    = rst_n && free && req0_valid && (!req1_valid || !prio_q);
        grant1    = rst_n && free && req1_valid && (!req0_valid || prio_q);
        sel_op    = grant1 ? req1_op : req0_op;
        sel_a     = grant1 ? req1_a : req0_a;
        sel_s     = grant1 ? req1_b[4:0] : req0_b[4:0];
        shift_res = do_shift(sel_op, sel_a, sel_s);
    end

    always_comb begin
        full_d  = full_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (drain) begin
            full_d = 1'b0;
            cnt_d  = cnt_q + 16'd1;
        end
        if (grant0 || grant1) begin
            full_d  = 1'b1;
            owner_d = grant1;
            data_d  = shift_res;
            prio_d  = !grant1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            data_q  <= '0;
            cnt_q   <= 16'd0;
        end else begin
            full_q  <= full_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = full_q && !owner_q;
    assign rsp1_valid = full_q && owner_q;
    assign rsp_data   = data_q;
    assign op_count   = cnt_q;

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares a single 32-bit shift unit (sll/srl/sra/rotl, shift amount from operand B[4:0]) between two requesters, e.g. the integer pipeline and the multi-cycle CP0/OS helper path. It uses round-robin arbitration with valid/ready handshakes. Each result is held in a registered slot until its owner accepts it. Throughput is one operation per cycle when consumers do not stall.

## Interface
- WIDTH, 32: datapath width. Fixed at 32; the shift amount is always B[4:0].
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  2  00 sll, 01 srl, 10 rotl, 11 sra.
- req0_a  in  32  value to shift.
- req0_b  in  32  shift amount source; only bits [4:0] are used.
- req1_valid / req1_ready / req1_op / req1_a / req1_b: same as requester 0, for requester 1.
- rsp0_valid  out  1  result slot holds a result owned by requester 0.
- rsp0_ready  in  1  requester 0 consumes its result.
- rsp1_valid / rsp1_ready: same as requester 0, for requester 1.
- rsp_data  out  32  result slot contents. Shared; meaningful only while rspN_valid is high.
- op_count  out  16  number of results consumed; wraps from 0xFFFF to 0x0000.

## Operation
- State: result slot consisting of full flag, owner bit, and 32-bit data. Priority pointer prio (0 or 1). op_count.
- Slot free this cycle: `free = !full || (rsp_valid[owner] && rsp_ready[owner])`. A drain and a new grant may happen in the same cycle.
- Grant, combinational:
  - No grant when !free.
  - Only one requester valid: grant it.
  - Both valid: grant the requester indexed by prio.
- reqN_ready = grant to N.
- Requesters must not make reqN_valid depend on reqN_ready. Once raised, valid and the operands are held until ready.
- On a granted edge:
  - slot ← {full=1, owner=N, data=shift(opN, aN, bN[4:0])}.
  - prio ← the other requester. prio changes only on a grant.
- Shift rules, with s = b[4:0]:
  - sll: zero-fill from the LSB.
  - srl: zero-fill from the MSB.
  - sra: replicate a[31].
  - rotl: (a << s) | (a >> (32-s)). For s=0 the result is a.
  - s=0 returns a for every op. Bits b[31:5] are ignored.
- Drain with no grant in the same cycle: full ← 0. op_count increments on every drain edge.
- rspN_valid = full && owner==N. rsp_data holds its value while full and unaccepted; it does not change under backpressure.
- rspM_ready for the non-owner M is ignored.

## Timing
- Reset, asynchronous, immediate on rst_n low:
  - full=0, owner=0, rsp_data=0, prio=0, op_count=0.
  - Therefore rsp0_valid=rsp1_valid=0.
  - reqN_ready is low while rst_n is low.
- Reset during a held result discards the result. No response is produced and op_count is not incremented.
- Latency: request accepted at edge k → rspN_valid and rsp_data valid after edge k, i.e. in cycle k+1.
- Back-to-back: result drained at edge k+1 while a new request is granted at the same edge → the next result is visible in cycle k+2, with no bubble.
- Owner stalls (rsp_ready low): slot stays full. Both reqN_ready stay low, including for the non-owner requester. This is head-of-line blocking by design.
- Simultaneous request from both requesters with prio=0: requester 0 wins. Requester 1 wins the next free cycle even if requester 0 re-requests.
- op_count wrap: 0xFFFF plus one drain → 0x0000, no flag.

## Test plan
- Single ops from requester 0 with rsp0_ready held high:
  - sll a=0x00000001, b=0x00000024 → 0x00000010.
  - srl a=0x80000000, b=31 → 0x00000001.
  - sra a=0x80000000, b=31 → 0xFFFFFFFF.
  - rotl a=0x80000001, b=1 → 0x00000003.
  - Each result appears one cycle after acceptance.
- Contention: both requesters valid continuously for 6 cycles, both rsp_ready high → grants alternate 0,1,0,1,0,1. Results arrive with owners in the same order, one per cycle. op_count=6.
- Backpressure: requester 1 result pending with rsp1_ready low for 5 cycles while requester 0 is valid → rsp_data stable, req0_ready low throughout. Raising rsp1_ready → requester 0 is granted the same cycle; its result appears next cycle.
- Ignored bits and zero shift: b=0xFFFFFFE0 (s=0) for all four ops with a=0xDEADBEEF → 0xDEADBEEF each time. A non-owner rsp_ready pulse does not drain the slot.
- Reset mid-operation: assert rst_n low while a result is held → rspN_valid drops immediately, op_count=0, prio=0. After release, a fresh simultaneous request grants requester 0.
- Counter wrap: force 65536 drains → op_count returns to 0x0000 with correct results throughout.
